axis_packet_dropper: RTL and testbench
======================================

# axis_packet_dropper

Packet-wise AXI-Stream sink/forwarder. Each packet arriving on `axis_i` consumes one command, which decides its fate: forwarded unchanged to `axis_o`, or accepted and discarded. Where a gater holds a stream back by stalling it, this block drains unwanted packets without stalling upstream. It sits behind packet classifiers (filters, checksum checkers) and keeps saturating counts of passed and dropped packets for status registers.

## Interface
- `AXIS_BYTES`, default 1: tdata width in bytes.
- `AXIS_USER_BITS`, default 1: tuser width.
- `COUNT_BITS`, default 16: width of each statistics counter.

Ports (one clock, `clk`; reset `sresetn` is synchronous and active-low):
- `clk` input 1: clock; all state changes on the rising edge.
- `sresetn` input 1: synchronous active-low reset.
- `c_valid` input 1: command valid.
- `c_ready` output 1: command accepted when `c_valid && c_ready`.
- `c_drop` input 1: command payload; 1 = discard the next packet, 0 = forward it.
- `axis_i_tready` output 1: input stream ready.
- `axis_i_tvalid` input 1: input stream valid.
- `axis_i_tlast` input 1: input stream last beat of packet.
- `axis_i_tdata` input AXIS_BYTES*8: input stream data.
- `axis_i_tuser` input AXIS_USER_BITS: input stream user sideband.
- `axis_o_tready` input 1: output stream ready.
- `axis_o_tvalid` output 1: output stream valid.
- `axis_o_tlast` output 1: output stream last beat of packet.
- `axis_o_tdata` output AXIS_BYTES*8: output stream data.
- `axis_o_tuser` output AXIS_USER_BITS: output stream user sideband.
- `stat_passed` output COUNT_BITS: packets forwarded, saturating.
- `stat_dropped` output COUNT_BITS: packets discarded, saturating.

## Operation
- State machine with three states: SM_IDLE, SM_PASS, SM_DROP.
- SM_IDLE:
  - Outputs: `c_ready`=1, `axis_i_tready`=0, `axis_o_tvalid`=0.
  - On `c_valid`, go to SM_DROP if `c_drop`=1, otherwise to SM_PASS.
- SM_PASS:
  - Outputs: `c_ready`=0, `axis_i_tready`=`axis_o_tready`, `axis_o_tvalid`=`axis_i_tvalid` (both combinational).
  - On a beat with `axis_o_tvalid && axis_o_tready && axis_o_tlast`: go to SM_IDLE and increment `stat_passed`.
- SM_DROP:
  - Outputs: `c_ready`=0, `axis_i_tready`=1, `axis_o_tvalid`=0.
  - Beats are consumed and discarded.
  - On `axis_i_tvalid && axis_i_tlast`: go to SM_IDLE and increment `stat_dropped`.
- `axis_o_tdata`, `axis_o_tuser` and `axis_o_tlast` always equal the corresponding `axis_i_*` inputs. They are meaningful only while `axis_o_tvalid`=1.
- Counters stick at 2^COUNT_BITS-1 and do not wrap.
- A command is bound to whole packets only. State never changes mid-packet except under reset.
- `c_drop` is sampled only on the cycle the command handshake completes.

## Timing
- Reset values: state SM_IDLE, `c_ready`=1, `axis_i_tready`=0, `axis_o_tvalid`=0, `stat_passed`=0, `stat_dropped`=0.
- Command accepted in cycle N; the first beat can transfer in cycle N+1.
- Forwarding path: zero latency, purely combinational in SM_PASS.
- Dropping throughput: 1 beat/cycle, no backpressure to upstream.
- After a last beat in cycle M, the block is in SM_IDLE in cycle M+1. A command presented there is accepted in M+1 and the next packet can move from M+2. This gives one mandatory bubble cycle between packets.
- Counters update on the clock edge that ends the packet. They are visible the cycle after the last beat.
- While in SM_IDLE, input data is stalled indefinitely until a command arrives. No beat is lost.
- `c_valid` asserted in SM_PASS or SM_DROP: held off (`c_ready`=0) until SM_IDLE.
- Single-beat packet (tlast on the first beat): handled like any other. The block is in SM_PASS or SM_DROP for exactly one transfer.
- In SM_PASS, `axis_o_tready`=0 stalls upstream. There is no timeout.
- Reset mid-packet: the block returns to SM_IDLE with counters cleared. Any remainder of that packet is treated as a new packet and needs a new command.

## Test plan
- Reset, then three 4-beat packets with commands pass/drop/pass, sink always ready. Required: `axis_o` carries packets 1 and 3 byte-exact, 8 beats total. Packet 2 is consumed in 4 cycles. `stat_passed`=2, `stat_dropped`=1.
- Input packet waiting with no command for 10 cycles. Required: `axis_i_tready`=0 throughout. Issue pass: the full packet appears on `axis_o` starting the cycle after acceptance.
- Pass a 5-beat packet with `axis_o_tready` toggling 1,0,1,0. Required: no beat duplicated or lost, `axis_i_tready` tracks `axis_o_tready` exactly. Drop a 5-beat packet while `axis_o_tready`=0. Required: it drains in 5 cycles.
- Back-to-back single-beat packets with `c_valid` held high, `c_drop`=0. Required: one packet every 2 cycles, `c_ready` high only in SM_IDLE cycles.
- `COUNT_BITS`=2, drop 5 packets. Required: `stat_dropped` reads 1,2,3,3,3 and `stat_passed` stays 0.
- Assert `sresetn`=0 for one cycle in beat 2 of a 4-beat passed packet. Required: the next cycle shows `axis_o_tvalid`=0, `c_ready`=1 and both counters 0. Beats 3-4 are held until a new command is accepted.

Source files
------------

// File: rtl/axis_packet_dropper.sv
// Packet-wise AXI-Stream forwarder/sink: every input packet consumes one command that
// either forwards it unchanged or drains it, with saturating pass/drop statistics.
module axis_packet_dropper #(
    parameter int AXIS_BYTES     = 1,
    parameter int AXIS_USER_BITS = 1,
    parameter int COUNT_BITS     = 16
) (
    input  logic                        clk,
    input  logic                        sresetn,
    input  logic                        c_valid,
    output logic                        c_ready,
    input  logic                        c_drop,
    output logic                        axis_i_tready,
    input  logic                        axis_i_tvalid,
    input  logic                        axis_i_tlast,
    input  logic [AXIS_BYTES*8-1:0]     axis_i_tdata,
    input  logic [AXIS_USER_BITS-1:0]   axis_i_tuser,
    input  logic                        axis_o_tready,
    output logic                        axis_o_tvalid,
    output logic                        axis_o_tlast,
    output logic [AXIS_BYTES*8-1:0]     axis_o_tdata,
    output logic [AXIS_USER_BITS-1:0]   axis_o_tuser,
    output logic [COUNT_BITS-1:0]       stat_passed,
    output logic [COUNT_BITS-1:0]       stat_dropped
);

    // Handshakes: a transfer (command or beat) happens on a rising edge where valid and
    // ready are both high; the sender holds valid and payload stable until that edge.
    typedef enum logic [1:0] {
        SM_IDLE,
        SM_PASS,
        SM_DROP
    } state_t;

    state_t state;
    state_t state_next;
    logic   pass_done;
    logic   drop_done;

    always_comb begin
        state_next    = state;
        c_ready       = 1'b0;
        axis_i_tready = 1'b0;
        axis_o_tvalid = 1'b0;
        pass_done     = 1'b0;
        drop_done     = 1'b0;
        case (state)
            SM_IDLE: begin
                c_ready = 1'b1;
                if (c_valid) begin
                    state_next = c_drop ? SM_DROP : SM_PASS;
                end
            end
            SM_PASS: begin
                axis_i_tready = axis_o_tready;
                axis_o_tvalid = axis_i_tvalid;
                if (axis_i_tvalid && axis_o_tready && axis_i_tlast) begin
                    pass_done  = 1'b1;
                    state_next = SM_IDLE;
                end
            end
            SM_DROP: begin
                // Draining never backpressures, so every valid beat is a transfer.
                axis_i_tready = 1'b1;
                if (axis_i_tvalid && axis_i_tlast) begin
                    drop_done  = 1'b1;
                    state_next = SM_IDLE;
                end
            end
            default: state_next = SM_IDLE;
        endcase
    end

    assign axis_o_tlast = axis_i_tlast;
    assign axis_o_tdata = axis_i_tdata;
    assign axis_o_tuser = axis_i_tuser;

    always_ff @(posedge clk) begin
        if (!sresetn) begin
            state        <= SM_IDLE;
            stat_passed  <= '0;
            stat_dropped <= '0;
        end else begin
            state <= state_next;
            if (pass_done && (stat_passed != {COUNT_BITS{1'b1}})) begin
                stat_passed <= stat_passed + 1'b1;
            end
            if (drop_done && (stat_dropped != {COUNT_BITS{1'b1}})) begin
                stat_dropped <= stat_dropped + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axis_packet_dropper.sv
// Bench for axis_packet_dropper: directed scenarios plus randomized traffic checked every
// cycle against a command/packet level model and an expected-beat queue.
module tb_axis_packet_dropper;

    localparam int AXIS_BYTES = 2;
    localparam int USER_BITS  = 2;
    localparam int CB         = 2;
    localparam int DW         = AXIS_BYTES * 8;
    localparam int BW         = 1 + USER_BITS + DW;
    localparam int CMAX       = (1 << CB) - 1;
    localparam int BUDGET     = 500;

    logic                 clk;
    logic                 sresetn;
    logic                 c_valid;
    logic                 c_ready;
    logic                 c_drop;
    logic                 axis_i_tready;
    logic                 axis_i_tvalid;
    logic                 axis_i_tlast;
    logic [DW-1:0]        axis_i_tdata;
    logic [USER_BITS-1:0] axis_i_tuser;
    logic                 axis_o_tready;
    logic                 axis_o_tvalid;
    logic                 axis_o_tlast;
    logic [DW-1:0]        axis_o_tdata;
    logic [USER_BITS-1:0] axis_o_tuser;
    logic [CB-1:0]        stat_passed;
    logic [CB-1:0]        stat_dropped;

    axis_packet_dropper #(
        .AXIS_BYTES(AXIS_BYTES),
        .AXIS_USER_BITS(USER_BITS),
        .COUNT_BITS(CB)
    ) dut (
        .clk(clk),
        .sresetn(sresetn),
        .c_valid(c_valid),
        .c_ready(c_ready),
        .c_drop(c_drop),
        .axis_i_tready(axis_i_tready),
        .axis_i_tvalid(axis_i_tvalid),
        .axis_i_tlast(axis_i_tlast),
        .axis_i_tdata(axis_i_tdata),
        .axis_i_tuser(axis_i_tuser),
        .axis_o_tready(axis_o_tready),
        .axis_o_tvalid(axis_o_tvalid),
        .axis_o_tlast(axis_o_tlast),
        .axis_o_tdata(axis_o_tdata),
        .axis_o_tuser(axis_o_tuser),
        .stat_passed(stat_passed),
        .stat_dropped(stat_dropped)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [BW-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit chk_en   = 0;
    bit m_busy   = 0;
    bit m_drop   = 0;
    int m_pass   = 0;
    int m_dropc  = 0;
    int o_cyc_q[$];
    int i_cyc_q[$];
    int cmd_cyc_q[$];
    bit drops_q[$];
    int lens_q[$];
    int sink_mode = 0;
    bit tog = 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    // Model: a command opens a packet window; in the window a pass packet mirrors the sink's
    // ready, a drop packet is always accepted; the window closes at the packet's last beat.
    always @(negedge clk) begin
        logic          exp_cr;
        logic          exp_itr;
        logic          exp_ov;
        logic [BW-1:0] beat;
        cyc++;
        exp_cr  = !m_busy;
        exp_itr = m_busy && (m_drop || axis_o_tready);
        exp_ov  = m_busy && !m_drop && axis_i_tvalid;
        if (chk_en) begin
            chk("c_ready", c_ready, exp_cr);
            chk("axis_i_tready", axis_i_tready, exp_itr);
            chk("axis_o_tvalid", axis_o_tvalid, exp_ov);
            chk("stat_passed", stat_passed, m_pass);
            chk("stat_dropped", stat_dropped, m_dropc);
            if (axis_o_tvalid === 1'b1 && axis_o_tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_beat", {axis_o_tlast, axis_o_tuser, axis_o_tdata}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    beat = exp_q.pop_front();
                    chk("out_beat", {axis_o_tlast, axis_o_tuser, axis_o_tdata}, beat);
                end
                o_cyc_q.push_back(cyc);
            end
            if (axis_i_tvalid && axis_i_tready === 1'b1) i_cyc_q.push_back(cyc);
            if (c_valid && c_ready === 1'b1) cmd_cyc_q.push_back(cyc);
        end
        if (!sresetn) begin
            m_busy  = 0;
            m_pass  = 0;
            m_dropc = 0;
        end else if (!m_busy) begin
            if (c_valid) begin
                m_busy = 1;
                m_drop = c_drop;
            end
        end else if (axis_i_tvalid && exp_itr && axis_i_tlast) begin
            m_busy = 0;
            if (m_drop) m_dropc = sat_inc(m_dropc);
            else m_pass = sat_inc(m_pass);
        end
    end

    // ---------------- sink ----------------
    always @(posedge clk) begin
        #1;
        case (sink_mode)
            0: axis_o_tready = 1'b1;
            1: axis_o_tready = 1'($urandom_range(0, 1));
            2: begin
                axis_o_tready = tog;
                tog = !tog;
            end
            default: axis_o_tready = 1'b0;
        endcase
    end

    // ---------------- drivers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_hs(input bit is_cmd);
        int n;
        bit got;
        n = 0;
        do begin
            @(negedge clk);
            got = is_cmd ? c_ready : axis_i_tready;
            step();
            n++;
        end while (!got && n < BUDGET);
        if (!got) chk(is_cmd ? "cmd_timeout" : "beat_timeout", 0, 1);
    endtask

    task automatic do_reset();
        sresetn = 1'b0;
        step();
        sresetn = 1'b1;
    endtask

    task automatic set_beat(input bit last);
        axis_i_tvalid = 1'b1;
        axis_i_tlast  = last;
        axis_i_tdata  = DW'($urandom);
        axis_i_tuser  = USER_BITS'($urandom);
    endtask

    task automatic cmd_driver(input int max_gap);
        foreach (drops_q[k]) begin
            repeat ($urandom_range(0, max_gap)) begin
                c_valid = 1'b0;
                c_drop  = 1'($urandom_range(0, 1));
                step();
            end
            c_valid = 1'b1;
            c_drop  = drops_q[k];
            wait_hs(1);
        end
        c_valid = 1'b0;
    endtask

    task automatic data_driver(input int max_gap);
        foreach (lens_q[k]) begin
            for (int b = 0; b < lens_q[k]; b++) begin
                repeat ($urandom_range(0, max_gap)) begin
                    axis_i_tvalid = 1'b0;
                    axis_i_tdata  = DW'($urandom);
                    step();
                end
                set_beat(b == lens_q[k] - 1);
                if (!drops_q[k]) exp_q.push_back({axis_i_tlast, axis_i_tuser, axis_i_tdata});
                wait_hs(0);
            end
        end
        axis_i_tvalid = 1'b0;
    endtask

    task automatic run_stream(input int cmd_gap, input int data_gap);
        fork
            cmd_driver(cmd_gap);
            data_driver(data_gap);
        join
    endtask

    task automatic clear_logs();
        o_cyc_q.delete();
        i_cyc_q.delete();
        cmd_cyc_q.delete();
    endtask

    task automatic settle();
        repeat (3) step();
        @(negedge clk);
    endtask

    // ---------------- test sequence ----------------
    int exp_d[5] = '{1, 2, 3, 3, 3};

    initial begin
        sresetn = 1'b0;
        c_valid = 1'b0;
        c_drop = 1'b0;
        axis_i_tvalid = 1'b0;
        axis_i_tlast = 1'b0;
        axis_i_tdata = '0;
        axis_i_tuser = '0;
        axis_o_tready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        sresetn = 1'b1;
        chk_en = 1;
        @(negedge clk);
        chk("reset_c_ready", c_ready, 1);
        chk("reset_i_tready", axis_i_tready, 0);
        chk("reset_o_tvalid", axis_o_tvalid, 0);
        chk("reset_stat_passed", stat_passed, 0);
        chk("reset_stat_dropped", stat_dropped, 0);
        step();

        // pass / drop / pass, 4 beats each
        clear_logs();
        drops_q = {1'b0, 1'b1, 1'b0};
        lens_q = {4, 4, 4};
        run_stream(0, 0);
        settle();
        chk("t1_out_beats", o_cyc_q.size(), 8);
        chk("t1_stat_passed", stat_passed, 2);
        chk("t1_stat_dropped", stat_dropped, 1);
        chk("t1_in_beats", i_cyc_q.size(), 12);
        if (i_cyc_q.size() == 12) chk("t1_drop_cycles", i_cyc_q[7] - i_cyc_q[4] + 1, 4);
        step();

        // packet waits 10 cycles without a command
        clear_logs();
        drops_q = {1'b0};
        lens_q = {5};
        fork
            data_driver(0);
            begin
                repeat (10) begin
                    @(negedge clk);
                    chk("t2_stalled_tready", axis_i_tready, 0);
                    step();
                end
                c_valid = 1'b1;
                c_drop = 1'b0;
                wait_hs(1);
                c_valid = 1'b0;
            end
        join
        settle();
        chk("t2_out_beats", o_cyc_q.size(), 5);
        if (o_cyc_q.size() > 0 && cmd_cyc_q.size() == 1)
            chk("t2_first_beat_latency", o_cyc_q[0] - cmd_cyc_q[0], 1);
        else chk("t2_logs", cmd_cyc_q.size(), 1);
        step();

        // pass with toggling sink, then drop with a stalled sink
        clear_logs();
        tog = 1;
        sink_mode = 2;
        step();
        drops_q = {1'b0};
        lens_q = {5};
        run_stream(0, 0);
        sink_mode = 3;
        settle();
        chk("t3_out_beats", o_cyc_q.size(), 5);
        step();
        clear_logs();
        drops_q = {1'b1};
        lens_q = {5};
        run_stream(0, 0);
        settle();
        chk("t3_drop_in_beats", i_cyc_q.size(), 5);
        if (i_cyc_q.size() == 5) chk("t3_drain_cycles", i_cyc_q[4] - i_cyc_q[0] + 1, 5);
        chk("t3_drop_no_out", o_cyc_q.size(), 0);
        sink_mode = 0;
        step();

        // back-to-back single-beat packets, c_valid held
        clear_logs();
        drops_q = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        lens_q = {1, 1, 1, 1, 1, 1};
        run_stream(0, 0);
        settle();
        chk("t4_out_beats", o_cyc_q.size(), 6);
        for (int k = 1; k < i_cyc_q.size(); k++) chk("t4_packet_spacing", i_cyc_q[k] - i_cyc_q[k-1], 2);
        step();

        // saturating drop counter
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drops_q = {1'b1};
            lens_q = {2};
            run_stream(1, 0);
            @(negedge clk);
            chk("t5_stat_dropped", stat_dropped, exp_d[k]);
            chk("t5_stat_passed", stat_passed, 0);
            step();
        end

        // reset during beat 2 of a passed packet
        do_reset();
        sink_mode = 0;
        c_valid = 1'b1;
        c_drop = 1'b0;
        wait_hs(1);
        c_valid = 1'b0;
        set_beat(0);
        exp_q.push_back({axis_i_tlast, axis_i_tuser, axis_i_tdata});
        wait_hs(0);
        set_beat(0);
        exp_q.push_back({axis_i_tlast, axis_i_tuser, axis_i_tdata});
        sresetn = 1'b0;
        @(negedge clk);
        chk("t6_beat2_tready", axis_i_tready, 1);
        step();
        sresetn = 1'b1;
        set_beat(0);
        @(negedge clk);
        chk("t6_o_tvalid", axis_o_tvalid, 0);
        chk("t6_c_ready", c_ready, 1);
        chk("t6_stat_passed", stat_passed, 0);
        chk("t6_stat_dropped", stat_dropped, 0);
        chk("t6_held_tready", axis_i_tready, 0);
        repeat (4) begin
            step();
            @(negedge clk);
            chk("t6_held_tready", axis_i_tready, 0);
        end
        step();
        exp_q.push_back({axis_i_tlast, axis_i_tuser, axis_i_tdata});
        c_valid = 1'b1;
        c_drop = 1'b0;
        wait_hs(1);
        c_valid = 1'b0;
        wait_hs(0);
        set_beat(1);
        exp_q.push_back({axis_i_tlast, axis_i_tuser, axis_i_tdata});
        wait_hs(0);
        axis_i_tvalid = 1'b0;
        settle();
        chk("t6_stat_passed_after", stat_passed, 1);
        chk("t6_exp_empty", exp_q.size(), 0);
        step();

        // randomized traffic, several rounds separated by resets
        sink_mode = 1;
        for (int r = 0; r < 4; r++) begin
            do_reset();
            drops_q.delete();
            lens_q.delete();
            for (int k = 0; k < 40; k++) begin
                drops_q.push_back(1'($urandom_range(0, 1)));
                lens_q.push_back($urandom_range(1, 6));
            end
            run_stream(3, 2);
            settle();
            chk("rand_exp_empty", exp_q.size(), 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
